// File: rtl/token_bucket_gate_if.sv
// Request handshake between a requester and the token-bucket gate.
// The grant pulse travels with the handshake because it feeds the downstream trigger.
interface token_bucket_gate_if;
    logic req_valid;
    logic req_ready;
    logic grant;

    modport master (
        output req_valid,
        input  req_ready,
        input  grant
    );

    modport slave (
        input  req_valid,
        output req_ready,
        output grant
    );
endinterface

// File: rtl/token_bucket_gate.sv
// Token-bucket rate limiter: one token per accepted request, periodic refill, and a
// forced low gap after each grant so every grant is a distinct rising edge downstream.
module token_bucket_gate #(
    parameter int BUCKET_DEPTH  = 4,
    parameter int INIT_TOKENS   = 4,
    parameter int REFILL_PERIOD = 8,
    parameter int REFILL_AMOUNT = 1,
    parameter int GAP_CYCLES    = 1,
    localparam int TW = (BUCKET_DEPTH + 1 > 2) ? $clog2(BUCKET_DEPTH + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  refill_en_i,
    token_bucket_gate_if.slave    req,
    output logic [TW-1:0]         tokens_o,
    output logic                  bucket_full_o,
    output logic                  refill_sat_o
);
    localparam int TMW = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
    localparam int GW  = (GAP_CYCLES >= 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int SW  = TW + 1;
    // Any amount above the depth clips identically, so cap it to keep the sum within SW bits.
    localparam int AMT = (REFILL_AMOUNT > BUCKET_DEPTH) ? BUCKET_DEPTH + 1 : REFILL_AMOUNT;

    if (BUCKET_DEPTH < 1 || INIT_TOKENS < 0 || INIT_TOKENS > BUCKET_DEPTH ||
        REFILL_PERIOD < 1 || REFILL_AMOUNT < 1 || GAP_CYCLES < 1) begin : g_param_check
        $error("token_bucket_gate: parameter out of range");
    end

    typedef enum logic {
        ST_READY = 1'b0,
        ST_GAP   = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [TMW-1:0]  timer_q, timer_d;
    logic [TW-1:0]   tok_q, tok_d;
    logic            grant_q, grant_d;
    logic            sat_q, sat_d;
    logic            tick;
    logic            ready;
    logic            accept;
    logic [SW-1:0]   sum;

    always_comb begin
        tick    = refill_en_i && (timer_q == TMW'(REFILL_PERIOD - 1));
        timer_d = timer_q;
        if (refill_en_i) begin
            timer_d = tick ? '0 : timer_q + TMW'(1);
        end

        state_d = state_q;
        gap_d   = gap_q;
        ready   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_READY: begin
                ready  = (tok_q != '0);
                accept = req.req_valid && ready;
                if (accept) begin
                    state_d = ST_GAP;
                    gap_d   = GW'(GAP_CYCLES);
                end
            end
            ST_GAP: begin
                gap_d = gap_q - GW'(1);
                if (gap_q == GW'(1)) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_READY;
        endcase

        // Accept is decided on the pre-update count, so a same-cycle tick never rescues an empty bucket.
        sum = {1'b0, tok_q} - SW'(accept) + (tick ? SW'(AMT) : '0);
        if (sum > SW'(BUCKET_DEPTH)) begin
            tok_d = TW'(BUCKET_DEPTH);
            sat_d = 1'b1;
        end else begin
            tok_d = sum[TW-1:0];
            sat_d = 1'b0;
        end
        grant_d = accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_READY;
            gap_q   <= '0;
            timer_q <= '0;
            tok_q   <= TW'(INIT_TOKENS);
            grant_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            timer_q <= timer_d;
            tok_q   <= tok_d;
            grant_q <= grant_d;
            sat_q   <= sat_d;
        end
    end

    assign req.req_ready  = ready;
    assign req.grant      = grant_q;
    assign tokens_o       = tok_q;
    assign bucket_full_o  = (tok_q == TW'(BUCKET_DEPTH));
    assign refill_sat_o   = sat_q;
endmodule

// File: tb/tb_token_bucket_gate.sv
// Bench for token_bucket_gate: vector table, hand-written corner sequences and a
// randomized run, all cross-checked against a cycle-level token-bucket model.
module tb_token_bucket_gate;
    localparam int D    = 4;
    localparam int INIT = 4;
    localparam int P    = 8;
    localparam int A    = 1;
    localparam int G    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, refill_en;
    logic [2:0] tokens;
    logic       full, sat;
    token_bucket_gate_if bus ();

    logic       rst2;
    logic [2:0] tokens2;
    logic       full2, sat2;
    token_bucket_gate_if bus2 ();

    token_bucket_gate dut (
        .clk           (clk),
        .rst           (rst),
        .refill_en_i   (refill_en),
        .req           (bus),
        .tokens_o      (tokens),
        .bucket_full_o (full),
        .refill_sat_o  (sat)
    );

    token_bucket_gate #(.GAP_CYCLES(3)) dut3 (
        .clk           (clk),
        .rst           (rst2),
        .refill_en_i   (1'b0),
        .req           (bus2),
        .tokens_o      (tokens2),
        .bucket_full_o (full2),
        .refill_sat_o  (sat2)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference bucket: token count, refill phase, remaining gap cycles.
    int m_tok, m_timer, m_gap, m_grant, m_sat;
    bit mv = 1'b0;

    int s_ready, s_grant, s_tok, s_full, s_sat;
    int s2_ready, s2_grant, s2_tok;
    int grant_prev = 0, grant_rise = 0, sat_pulses = 0;

    typedef struct {
        bit rst;
        bit en;
        bit v;
        bit chk;
        int ready;
        int grant;
        int tok;
        int full;
        int sat;
    } vec_t;
    vec_t vt[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        int m_ready, acc, tk, nxt;
        @(negedge clk);
        s_ready  = int'(bus.req_ready);
        s_grant  = int'(bus.grant);
        s_tok    = int'(tokens);
        s_full   = int'(full);
        s_sat    = int'(sat);
        s2_ready = int'(bus2.req_ready);
        s2_grant = int'(bus2.grant);
        s2_tok   = int'(tokens2);
        if (s_grant != 0 && grant_prev == 0) grant_rise++;
        grant_prev = s_grant;
        if (s_sat != 0) sat_pulses++;
        m_ready = (m_gap == 0 && m_tok > 0) ? 1 : 0;
        if (mv) begin
            check("mdl_ready", s_ready, m_ready);
            check("mdl_grant", s_grant, m_grant);
            check("mdl_tokens", s_tok, m_tok);
            check("mdl_full", s_full, (m_tok == D) ? 1 : 0);
            check("mdl_sat", s_sat, m_sat);
        end
        if (rst) begin
            m_tok = INIT; m_timer = 0; m_gap = 0; m_grant = 0; m_sat = 0;
            mv = 1'b1;
        end else begin
            tk    = (refill_en && m_timer == P - 1) ? 1 : 0;
            acc   = (bus.req_valid && m_ready != 0) ? 1 : 0;
            nxt   = m_tok - acc + (tk != 0 ? A : 0);
            m_sat = (nxt > D) ? 1 : 0;
            m_tok = (nxt > D) ? D : nxt;
            if (refill_en) m_timer = (tk != 0) ? 0 : m_timer + 1;
            m_gap   = (acc != 0) ? G : ((m_gap > 0) ? m_gap - 1 : 0);
            m_grant = acc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b1; refill_en = 1'b0; bus.req_valid = 1'b0;
        rst2 = 1'b1; bus2.req_valid = 1'b0;

        // Reset, then a burst with refill off: accepts every other cycle until empty.
        vt.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0});
        vt.push_back('{1, 0, 0, 1, 1, 0, 4, 1, 0});
        vt.push_back('{0, 0, 1, 1, 1, 0, 4, 1, 0});
        vt.push_back('{0, 0, 1, 1, 0, 1, 3, 0, 0});
        vt.push_back('{0, 0, 1, 1, 1, 0, 3, 0, 0});
        vt.push_back('{0, 0, 1, 1, 0, 1, 2, 0, 0});
        vt.push_back('{0, 0, 1, 1, 1, 0, 2, 0, 0});
        vt.push_back('{0, 0, 1, 1, 0, 1, 1, 0, 0});
        vt.push_back('{0, 0, 1, 1, 1, 0, 1, 0, 0});
        vt.push_back('{0, 0, 1, 1, 0, 1, 0, 0, 0});
        vt.push_back('{0, 0, 1, 1, 0, 0, 0, 0, 0});
        vt.push_back('{0, 0, 1, 1, 0, 0, 0, 0, 0});

        foreach (vt[i]) begin
            rst = vt[i].rst; refill_en = vt[i].en; bus.req_valid = vt[i].v;
            if (i == 2) grant_rise = 0;
            step();
            if (vt[i].chk) begin
                check($sformatf("tbl_ready[%0d]", i), s_ready, vt[i].ready);
                check($sformatf("tbl_grant[%0d]", i), s_grant, vt[i].grant);
                check($sformatf("tbl_tokens[%0d]", i), s_tok, vt[i].tok);
                check($sformatf("tbl_full[%0d]", i), s_full, vt[i].full);
                check($sformatf("tbl_sat[%0d]", i), s_sat, vt[i].sat);
            end
        end
        check("burst_grant_edges", grant_rise, 4);

        // Refill from empty: one token per 8 cycles, fifth tick clipped.
        bus.req_valid = 1'b0; refill_en = 1'b1;
        step();
        sat_pulses = 0;
        for (int k = 1; k <= 5; k++) begin
            repeat (8) step();
            check($sformatf("refill_tokens[%0d]", k), s_tok, (k < 4) ? k : 4);
            check($sformatf("refill_sat[%0d]", k), s_sat, (k == 5) ? 1 : 0);
        end
        check("refill_sat_pulses", sat_pulses, 1);

        // Spend down to one token, then accept in the tick cycle.
        bus.req_valid = 1'b1;
        repeat (5) step();
        bus.req_valid = 1'b0;
        step();
        bus.req_valid = 1'b1;
        step();
        check("simul_pre_tokens", s_tok, 1);
        check("simul_pre_ready", s_ready, 1);
        bus.req_valid = 1'b0;
        step();
        check("simul_tokens", s_tok, 1);
        check("simul_sat", s_sat, 0);
        check("simul_grant", s_grant, 1);

        // Empty bucket in the tick cycle: not ready until the cycle after.
        bus.req_valid = 1'b1;
        repeat (6) step();
        step();
        check("empty_tick_ready", s_ready, 0);
        check("empty_tick_tokens", s_tok, 0);
        step();
        check("after_tick_ready", s_ready, 1);
        check("after_tick_tokens", s_tok, 1);
        bus.req_valid = 1'b0;
        step();
        check("after_tick_grant", s_grant, 1);
        check("after_tick_spent", s_tok, 0);

        // Reset in the middle of a 3-cycle gap, then reset against a same-cycle accept.
        bus2.req_valid = 1'b1; rst2 = 1'b0;
        step();
        check("g3_c0_ready", s2_ready, 1);
        step();
        check("g3_c1_grant", s2_grant, 1);
        check("g3_c1_tokens", s2_tok, 3);
        check("g3_c1_ready", s2_ready, 0);
        rst2 = 1'b1;
        step();
        check("g3_c2_ready", s2_ready, 0);
        step();
        check("g3_post_rst_ready", s2_ready, 1);
        check("g3_post_rst_tokens", s2_tok, 4);
        check("g3_post_rst_grant", s2_grant, 0);
        rst2 = 1'b0;
        step();
        check("g3_acc_rst_grant", s2_grant, 0);
        check("g3_acc_rst_tokens", s2_tok, 4);
        check("g3_acc_rst_ready", s2_ready, 1);
        bus2.req_valid = 1'b0;

        // Randomized traffic against the model.
        rst = 1'b1; bus.req_valid = 1'b0;
        repeat (2) step();
        for (int n = 0; n < 600; n++) begin
            rst           = ($urandom_range(0, 79) == 0);
            refill_en     = ($urandom_range(0, 3) != 0);
            bus.req_valid = ($urandom_range(0, 4) < 3);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
